uart_cmd_bridge: RTL and testbench
==================================

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameter SLAVE_LEN, default 2, SHALL set the slave-select width (1..6).
REQ-002 Parameter ADDR_LEN, default 12, SHALL set the bus address width.
REQ-003 Parameter DATA_LEN, default 8, SHALL set the bus word width (multiple of 8).
REQ-004 Parameter BURST_LEN, default 12, SHALL set the burst-count width.
REQ-005 Parameter MAX_BURST, default 16, SHALL set the internal word-buffer depth (power of 2).
REQ-006 Parameter TIMEOUT, default 50000, SHALL set the inter-byte timeout in clk cycles.
REQ-007 Ports SHALL be, one per line:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- u_receive_sig  in  1  one-cycle strobe: u_data_in holds a received byte
- u_data_in  in  8  received UART byte
- u_send_sig  out  1  one-cycle request to transmit u_data_out
- u_data_out  out  8  byte to transmit
- u_tx_busy  in  1  UART transmitter busy
- u_tx_done  in  1  one-cycle strobe: byte transmitted
- m_instruction  out  2  00 idle, 01 read, 10 write
- m_slave_select  out  SLAVE_LEN  target slave
- m_address  out  ADDR_LEN  start address
- m_burst_num  out  BURST_LEN  word count N
- m_data_out  out  DATA_LEN  current write word
- m_tx_done  in  1  one-cycle strobe: current write word consumed
- m_new_rx  in  1  one-cycle strobe: m_data_in holds a read word
- m_data_in  in  DATA_LEN  read word
- m_rx_done  in  1  one-cycle strobe: read transaction ended

Function
REQ-008 Frame SHALL be: header byte (bits[7:6] opcode, bits[SLAVE_LEN-1:0] slave), ceil(ADDR_LEN/8) address bytes, ceil(BURST_LEN/8) burst bytes B, then for writes B*DATA_LEN/8 data bytes; all multi-byte fields MSB first, excess high bits discarded.
REQ-009 States SHALL be IDLE, ADDR, BURST, WDATA, DRAIN, BUS_WR, BUS_RD, TX_STATUS, TX_DATA.
REQ-010 IDLE SHALL go to ADDR on a header with opcode 01/10; opcodes 00/11 SHALL go to TX_STATUS with NAK 0x5A.
REQ-011 After BURST, B==0 or B>MAX_BURST SHALL select NAK: reads go to TX_STATUS; writes go to DRAIN, discard B*DATA_LEN/8 bytes, then TX_STATUS.
REQ-012 WDATA SHALL pack bytes into words and store them at buffer index 0..N-1, then enter BUS_WR.
REQ-013 In BUS_WR/BUS_RD m_instruction, m_slave_select, m_address, m_burst_num SHALL be held stable; m_instruction SHALL be 00 in every other state.
REQ-014 BUS_WR SHALL present word k on m_data_out, advance k on each m_tx_done, and after the N-th pulse enter TX_STATUS with ACK 0xA5.
REQ-015 BUS_RD SHALL store m_data_in on each m_new_rx (ignoring strobes beyond N); on m_rx_done or the N-th word, go to TX_STATUS: ACK if N words stored, else NAK.
REQ-016 m_new_rx and m_rx_done in the same cycle SHALL store the word before evaluating completion.
REQ-017 UART transmit SHALL pulse u_send_sig for one cycle only when u_tx_busy is low, and issue no next byte before u_tx_done.
REQ-018 After an ACK for a read, TX_DATA SHALL send N words, MSB byte first; all other status bytes SHALL return to IDLE after u_tx_done.
REQ-019 u_receive_sig outside IDLE/ADDR/BURST/WDATA/DRAIN SHALL be ignored.

Reset
REQ-020 Reset SHALL force IDLE, m_instruction=00, u_send_sig=0, u_data_out=0, m_slave_select/m_address/m_burst_num/m_data_out=0, counters=0, at any time including mid-transaction.

Configuration
REQ-021 With macro UART_BRIDGE_TIMEOUT_EN defined, TIMEOUT cycles without u_receive_sig in ADDR/BURST/WDATA/DRAIN SHALL abort the frame to TX_STATUS with NAK; undefined, those states SHALL wait indefinitely and no timeout counter SHALL exist.

Structure
REQ-022 Package bridge_pkg SHALL hold the opcode enum, state enum, ACK/NAK constants and byte-count functions.
REQ-023 Sub-module bridge_word_buffer SHALL implement the MAX_BURST x DATA_LEN word buffer (synchronous write, registered read).

Verification
REQ-024 Bytes 81,01,23,00,02,AA,BB; two m_tx_done pulses -> m_instruction=10, slave 1, addr 0x123, burst 2, m_data_out AA then BB; UART sends A5.
REQ-025 Bytes 42,00,10,00,03; m_new_rx with 11,22,33 -> m_instruction=01, slave 2, addr 0x010; UART sends A5,11,22,33.
REQ-026 Bytes 42,00,10,00,03; m_new_rx 11 then m_rx_done -> UART sends 5A only.
REQ-027 Bytes 81,00,00,00,20 then 32 data bytes -> bytes discarded, m_instruction stays 00, UART sends 5A; next valid frame succeeds.
REQ-028 With UART_BRIDGE_TIMEOUT_EN: bytes 81,01 then silence 50000 cycles -> UART sends 5A, state IDLE.
REQ-029 Reset asserted during BUS_WR -> m_instruction=00 and u_send_sig=0 immediately; a following frame completes normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types, status codes and frame helpers for the UART command bridge.
// Holds the opcode and state enums plus byte-count helpers for frame fields.
package bridge_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_WDATA,
        S_DRAIN,
        S_BUS_WR,
        S_BUS_RD,
        S_TX_STATUS,
        S_TX_DATA
    } state_e;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'h5A;

    // Number of UART bytes needed to carry a field of the given bit width.
    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/bridge_word_buffer.sv
// Word buffer shared by the write and read paths of the command bridge.
// Ports: clk/reset, write port (we, waddr, wdata), registered read (raddr -> rdata).
module bridge_word_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Forward a same-cycle write so a one-word burst reads its fresh value.
    always_comb begin
        rdata_d = mem_q[raddr];
        if (we && (waddr == raddr)) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART byte-stream to parallel bus command bridge (read/write bursts, ACK/NAK).
// Ports: u_* UART rx/tx handshake, m_* bus command, data and completion strobes.
// Optional macro UART_BRIDGE_TIMEOUT_EN aborts stalled frames after TIMEOUT cycles.
module uart_cmd_bridge
    import bridge_pkg::*;
#(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 u_receive_sig,
    input  logic [7:0]           u_data_in,
    output logic                 u_send_sig,
    output logic [7:0]           u_data_out,
    input  logic                 u_tx_busy,
    input  logic                 u_tx_done,
    output logic [1:0]           m_instruction,
    output logic [SLAVE_LEN-1:0] m_slave_select,
    output logic [ADDR_LEN-1:0]  m_address,
    output logic [BURST_LEN-1:0] m_burst_num,
    output logic [DATA_LEN-1:0]  m_data_out,
    input  logic                 m_tx_done,
    input  logic                 m_new_rx,
    input  logic [DATA_LEN-1:0]  m_data_in,
    input  logic                 m_rx_done
);

    localparam int ABYTES = bytes_for(ADDR_LEN);
    localparam int BBYTES = bytes_for(BURST_LEN);
    localparam int BPW    = DATA_LEN / 8;
    localparam int AW     = $clog2(MAX_BURST);
    localparam int CW     = $clog2(MAX_BURST + 1);
    localparam int PW     = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int FW     = BURST_LEN + PW + 1;
    localparam int CMPW   = (BURST_LEN > CW) ? BURST_LEN : CW;
    localparam logic [PW-1:0] BMAX = PW'(BPW - 1);

    state_e               state_q, state_d;
    opcode_e              op_q, op_d;
    logic [SLAVE_LEN-1:0] slave_q, slave_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [BURST_LEN-1:0] burst_q, burst_d;
    logic [CW-1:0]        nwords_q, nwords_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic [PW-1:0]        bcnt_q, bcnt_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic [DATA_LEN-1:0]  wword_q, wword_d;
    logic [7:0]           status_q, status_d;
    logic                 sent_q, sent_d;
    logic                 send_q, send_d;
    logic [7:0]           dout_q, dout_d;

    logic                 buf_we;
    logic [DATA_LEN-1:0]  buf_wdata;
    logic [DATA_LEN-1:0]  buf_rdata;
    logic                 burst_ok;
    logic [CW-1:0]        rd_cnt;
    logic [PW+2:0]        tx_shift;
    logic [7:0]           tx_byte;
    logic                 rx_state;
    logic                 tmo_hit;

    assign rx_state = (state_q == S_ADDR) || (state_q == S_BURST) ||
                      (state_q == S_WDATA) || (state_q == S_DRAIN);

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Counts consecutive silent cycles while a frame is being received.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (rx_state && !u_receive_sig) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    bridge_word_buffer #(
        .DEPTH (MAX_BURST),
        .WIDTH (DATA_LEN)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (wcnt_q[AW-1:0]),
        .wdata (buf_wdata),
        .raddr (wcnt_d[AW-1:0]),
        .rdata (buf_rdata)
    );

    // Buffer read address follows the next word index, so rdata tracks wcnt_q.
    assign tx_shift = {BMAX - bcnt_q, 3'b000};
    assign tx_byte  = 8'(buf_rdata >> tx_shift);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        slave_d   = slave_q;
        addr_d    = addr_q;
        burst_d   = burst_q;
        nwords_d  = nwords_q;
        wcnt_d    = wcnt_q;
        bcnt_d    = bcnt_q;
        fcnt_d    = fcnt_q;
        wword_d   = wword_q;
        status_d  = status_q;
        sent_d    = sent_q;
        send_d    = 1'b0;
        dout_d    = dout_q;
        buf_we    = 1'b0;
        buf_wdata = wword_q;
        burst_ok  = 1'b0;
        rd_cnt    = wcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (u_receive_sig) begin
                    op_d    = opcode_e'(u_data_in[7:6]);
                    slave_d = u_data_in[SLAVE_LEN-1:0];
                    fcnt_d  = '0;
                    if ((u_data_in[7:6] == OP_READ) ||
                        (u_data_in[7:6] == OP_WRITE)) begin
                        state_d = S_ADDR;
                    end else begin
                        status_d = NAK;
                        state_d  = S_TX_STATUS;
                    end
                end
            end
            S_ADDR: begin
                if (u_receive_sig) begin
                    addr_d = ADDR_LEN'({addr_q, u_data_in});
                    if (fcnt_q == FW'(ABYTES - 1)) begin
                        fcnt_d  = '0;
                        state_d = S_BURST;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            S_BURST: begin
                if (u_receive_sig) begin
                    burst_d = BURST_LEN'({burst_q, u_data_in});
                    if (fcnt_q == FW'(BBYTES - 1)) begin
                        burst_ok = (burst_d != '0) &&
                                   (CMPW'(burst_d) <= CMPW'(MAX_BURST));
                        nwords_d = CW'(burst_d);
                        fcnt_d   = '0;
                        wcnt_d   = '0;
                        bcnt_d   = '0;
                        if (burst_ok) begin
                            state_d = (op_q == OP_READ) ? S_BUS_RD : S_WDATA;
                        end else if ((op_q == OP_WRITE) && (burst_d != '0)) begin
                            // Swallow the payload so it is not parsed as headers.
                            fcnt_d  = FW'(burst_d) * FW'(BPW);
                            state_d = S_DRAIN;
                        end else begin
                            status_d = NAK;
                            state_d  = S_TX_STATUS;
                        end
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            S_WDATA: begin
                if (u_receive_sig) begin
                    wword_d = DATA_LEN'({wword_q, u_data_in});
                    if (bcnt_q == BMAX) begin
                        bcnt_d    = '0;
                        buf_we    = 1'b1;
                        buf_wdata = wword_d;
                        if (wcnt_q == nwords_q - CW'(1)) begin
                            wcnt_d  = '0;
                            state_d = S_BUS_WR;
                        end else begin
                            wcnt_d = wcnt_q + CW'(1);
                        end
                    end else begin
                        bcnt_d = bcnt_q + PW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (u_receive_sig) begin
                    fcnt_d = fcnt_q - FW'(1);
                    if (fcnt_q == FW'(1)) begin
                        status_d = NAK;
                        state_d  = S_TX_STATUS;
                    end
                end
            end
            S_BUS_WR: begin
                if (m_tx_done) begin
                    if (wcnt_q == nwords_q - CW'(1)) begin
                        wcnt_d   = '0;
                        status_d = ACK;
                        state_d  = S_TX_STATUS;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
            end
            S_BUS_RD: begin
                // Store first, then judge completion on the updated count.
                if (m_new_rx && (wcnt_q < nwords_q)) begin
                    buf_we    = 1'b1;
                    buf_wdata = m_data_in;
                    rd_cnt    = wcnt_q + CW'(1);
                end
                wcnt_d = rd_cnt;
                if (m_rx_done || (rd_cnt == nwords_q)) begin
                    status_d = (rd_cnt == nwords_q) ? ACK : NAK;
                    wcnt_d   = '0;
                    state_d  = S_TX_STATUS;
                end
            end
            S_TX_STATUS: begin
                wcnt_d = '0;
                bcnt_d = '0;
                if (!sent_q) begin
                    if (!u_tx_busy) begin
                        send_d = 1'b1;
                        dout_d = status_q;
                        sent_d = 1'b1;
                    end
                end else if (u_tx_done) begin
                    sent_d = 1'b0;
                    if ((status_q == ACK) && (op_q == OP_READ)) begin
                        state_d = S_TX_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TX_DATA: begin
                if (!sent_q) begin
                    if (!u_tx_busy) begin
                        send_d = 1'b1;
                        dout_d = tx_byte;
                        sent_d = 1'b1;
                    end
                end else if (u_tx_done) begin
                    sent_d = 1'b0;
                    if (bcnt_q == BMAX) begin
                        bcnt_d = '0;
                        if (wcnt_q == nwords_q - CW'(1)) begin
                            wcnt_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            wcnt_d = wcnt_q + CW'(1);
                        end
                    end else begin
                        bcnt_d = bcnt_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_hit) begin
            status_d = NAK;
            fcnt_d   = '0;
            wcnt_d   = '0;
            bcnt_d   = '0;
            state_d  = S_TX_STATUS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_IDLE;
            slave_q  <= '0;
            addr_q   <= '0;
            burst_q  <= '0;
            nwords_q <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            fcnt_q   <= '0;
            wword_q  <= '0;
            status_q <= '0;
            sent_q   <= 1'b0;
            send_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            slave_q  <= slave_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            nwords_q <= nwords_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            fcnt_q   <= fcnt_d;
            wword_q  <= wword_d;
            status_q <= status_d;
            sent_q   <= sent_d;
            send_q   <= send_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        m_instruction = OP_IDLE;
        if (state_q == S_BUS_WR) begin
            m_instruction = OP_WRITE;
        end else if (state_q == S_BUS_RD) begin
            m_instruction = OP_READ;
        end
    end

    assign m_data_out     = (state_q == S_BUS_WR) ? buf_rdata : '0;
    assign m_slave_select = slave_q;
    assign m_address      = addr_q;
    assign m_burst_num    = burst_q;
    assign u_send_sig     = send_q;
    assign u_data_out     = dout_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: frame table plus reset/timeout sequences.
// UART bytes and bus write words are checked against scoreboard queues.
module tb_uart_cmd_bridge;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  slv;
        logic [15:0] addr;
        logic [15:0] burst;
        int          nw;
        logic [31:0] d;
        int          mode;
        logic [7:0]  status;
        logic        bus;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        u_receive_sig;
    logic [7:0]  u_data_in;
    logic        u_send_sig;
    logic [7:0]  u_data_out;
    logic        u_tx_busy;
    logic        u_tx_done;
    logic [1:0]  m_instruction;
    logic [1:0]  m_slave_select;
    logic [11:0] m_address;
    logic [11:0] m_burst_num;
    logic [7:0]  m_data_out;
    logic        m_tx_done;
    logic        m_new_rx;
    logic [7:0]  m_data_in;
    logic        m_rx_done;

    int          n_cmp;
    int          n_fail;
    int          tx_cnt;
    logic        bus_seen;
    logic [7:0]  exp_uart[$];
    logic [7:0]  exp_wr[$];
    vec_t        tbl[14];

    uart_cmd_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .u_receive_sig  (u_receive_sig),
        .u_data_in      (u_data_in),
        .u_send_sig     (u_send_sig),
        .u_data_out     (u_data_out),
        .u_tx_busy      (u_tx_busy),
        .u_tx_done      (u_tx_done),
        .m_instruction  (m_instruction),
        .m_slave_select (m_slave_select),
        .m_address      (m_address),
        .m_burst_num    (m_burst_num),
        .m_data_out     (m_data_out),
        .m_tx_done      (m_tx_done),
        .m_new_rx       (m_new_rx),
        .m_data_in      (m_data_in),
        .m_rx_done      (m_rx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] wd(input vec_t v, input int i);
        logic [31:0] d;
        d = v.d;
        if (i < 4) return d[31-8*i -: 8];
        return 8'(i * 29 + 5);
    endfunction

    // UART transmitter model: busy for a few cycles, then a done strobe.
    initial begin
        tx_cnt = 0;
        forever begin
            @(negedge clk);
            if (u_send_sig) begin
                chk("uart_overlap", tx_cnt, 0);
                if (exp_uart.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL uart_extra: got 0x%0h, expected no byte",
                             u_data_out);
                end else begin
                    chk("uart_byte", u_data_out, exp_uart.pop_front());
                end
            end
            u_tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    u_tx_done = 1'b1;
                    u_tx_busy = 1'b0;
                end
            end
            if (u_send_sig) begin
                u_tx_busy = 1'b1;
                tx_cnt    = 3;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_instruction != 2'b00) bus_seen = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        u_data_in     = b;
        u_receive_sig = 1'b1;
        @(negedge clk);
        u_receive_sig = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        int b;
        b = int'(v.burst[11:0]);
        exp_uart.push_back(v.status);
        if (v.op == 2'b01 && v.status == 8'hA5) begin
            for (int i = 0; i < b; i++) exp_uart.push_back(wd(v, i));
        end
        send_byte({v.op, 4'b0000, v.slv});
        if (v.op == 2'b01 || v.op == 2'b10) begin
            send_byte(v.addr[15:8]);
            send_byte(v.addr[7:0]);
            send_byte(v.burst[15:8]);
            send_byte(v.burst[7:0]);
            if (v.op == 2'b10) begin
                for (int i = 0; i < b; i++) begin
                    if (v.bus) exp_wr.push_back(wd(v, i));
                    send_byte(wd(v, i));
                end
            end
        end
    endtask

    task automatic wait_bus();
        int k;
        k = 0;
        while (m_instruction == 2'b00 && k < 50) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic bus_phase(input vec_t v);
        int b;
        b = int'(v.burst[11:0]);
        if (v.bus) begin
            wait_bus();
            chk("bus_instr", m_instruction, v.op);
            chk("bus_slave", m_slave_select, v.slv);
            chk("bus_addr", m_address, v.addr[11:0]);
            chk("bus_burst", m_burst_num, v.burst[11:0]);
            if (v.op == 2'b10) begin
                for (int i = 0; i < b; i++) begin
                    if (exp_wr.size() > 0) begin
                        chk("wr_word", m_data_out, exp_wr.pop_front());
                    end
                    chk("wr_instr", m_instruction, 2'b10);
                    m_tx_done = 1'b1;
                    @(negedge clk);
                    m_tx_done = 1'b0;
                end
            end else begin
                for (int i = 0; i < v.nw; i++) begin
                    m_data_in = wd(v, i);
                    m_new_rx  = 1'b1;
                    if (v.mode == 2 && i == v.nw - 1) m_rx_done = 1'b1;
                    @(negedge clk);
                    m_new_rx  = 1'b0;
                    m_rx_done = 1'b0;
                end
                if (v.mode == 1) begin
                    m_rx_done = 1'b1;
                    @(negedge clk);
                    m_rx_done = 1'b0;
                end
            end
            chk("bus_end_instr", m_instruction, 2'b00);
        end
    endtask

    task automatic wait_uart(input int bound);
        int k;
        k = 0;
        while ((exp_uart.size() != 0 || tx_cnt != 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk("uart_pending", exp_uart.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        bus_seen = 1'b0;
        send_frame(v);
        bus_phase(v);
        wait_uart(3000);
        chk("bus_seen", bus_seen, v.bus);
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got no finish, expected finish by 2ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        bus_seen      = 1'b0;
        reset         = 1'b1;
        u_receive_sig = 1'b0;
        u_data_in     = 8'h00;
        u_tx_busy     = 1'b0;
        u_tx_done     = 1'b0;
        m_tx_done     = 1'b0;
        m_new_rx      = 1'b0;
        m_data_in     = 8'h00;
        m_rx_done     = 1'b0;

        tbl[0]  = '{op:2'b10, slv:2'd1, addr:16'h0123, burst:16'h0002, nw:2,
                    d:32'hAABB0000, mode:0, status:8'hA5, bus:1'b1};
        tbl[1]  = '{op:2'b01, slv:2'd2, addr:16'h0010, burst:16'h0003, nw:3,
                    d:32'h11223300, mode:0, status:8'hA5, bus:1'b1};
        tbl[2]  = '{op:2'b01, slv:2'd2, addr:16'h0010, burst:16'h0003, nw:1,
                    d:32'h11000000, mode:1, status:8'h5A, bus:1'b1};
        tbl[3]  = '{op:2'b10, slv:2'd0, addr:16'h0000, burst:16'h0020, nw:0,
                    d:32'h01020304, mode:0, status:8'h5A, bus:1'b0};
        tbl[4]  = '{op:2'b10, slv:2'd3, addr:16'h0FFF, burst:16'h0010, nw:0,
                    d:32'h01020304, mode:0, status:8'hA5, bus:1'b1};
        tbl[5]  = '{op:2'b01, slv:2'd1, addr:16'h0200, burst:16'h0000, nw:0,
                    d:32'h0, mode:0, status:8'h5A, bus:1'b0};
        tbl[6]  = '{op:2'b01, slv:2'd1, addr:16'h0200, burst:16'h0011, nw:0,
                    d:32'h0, mode:0, status:8'h5A, bus:1'b0};
        tbl[7]  = '{op:2'b00, slv:2'd1, addr:16'h0000, burst:16'h0000, nw:0,
                    d:32'h0, mode:0, status:8'h5A, bus:1'b0};
        tbl[8]  = '{op:2'b11, slv:2'd2, addr:16'h0000, burst:16'h0000, nw:0,
                    d:32'h0, mode:0, status:8'h5A, bus:1'b0};
        tbl[9]  = '{op:2'b10, slv:2'd1, addr:16'h0040, burst:16'h0000, nw:0,
                    d:32'h0, mode:0, status:8'h5A, bus:1'b0};
        tbl[10] = '{op:2'b10, slv:2'd2, addr:16'hF456, burst:16'hF001, nw:0,
                    d:32'h5C000000, mode:0, status:8'hA5, bus:1'b1};
        tbl[11] = '{op:2'b01, slv:2'd3, addr:16'h0ABC, burst:16'h0002, nw:2,
                    d:32'h77880000, mode:2, status:8'hA5, bus:1'b1};
        tbl[12] = '{op:2'b01, slv:2'd0, addr:16'h0777, burst:16'h0010, nw:16,
                    d:32'hC0C1C2C3, mode:0, status:8'hA5, bus:1'b1};
        tbl[13] = '{op:2'b10, slv:2'd1, addr:16'h0001, burst:16'h0011, nw:0,
                    d:32'h01020304, mode:0, status:8'h5A, bus:1'b0};

        repeat (3) @(negedge clk);
        chk("rst_instr", m_instruction, 2'b00);
        chk("rst_send", u_send_sig, 1'b0);
        chk("rst_udout", u_data_out, 8'h00);
        chk("rst_slave", m_slave_select, 2'd0);
        chk("rst_addr", m_address, 12'h000);
        chk("rst_burst", m_burst_num, 12'h000);
        chk("rst_mdout", m_data_out, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(tbl[i]);

        // Reset in the middle of a bus write burst.
        bus_seen = 1'b0;
        send_frame(tbl[0]);
        wait_bus();
        chk("mid_instr", m_instruction, 2'b10);
        m_tx_done = 1'b1;
        @(negedge clk);
        m_tx_done = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_instr", m_instruction, 2'b00);
        chk("mid_rst_send", u_send_sig, 1'b0);
        chk("mid_rst_mdout", m_data_out, 8'h00);
        exp_uart.delete();
        exp_wr.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vec(tbl[0]);

`ifdef UART_BRIDGE_TIMEOUT_EN
        bus_seen = 1'b0;
        exp_uart.push_back(8'h5A);
        send_byte(8'h81);
        send_byte(8'h01);
        wait_uart(60000);
        chk("tmo_bus_seen", bus_seen, 1'b0);
        run_vec(tbl[1]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
